mem_req_arb: RTL and testbench

- N-to-1 memory request arbiter with 1-to-N response router.
- Sits between per-cluster memory ports and the single shared memory port whenever the L3 cache is disabled.
- Requests are merged and tagged with the source index. Responses are routed back to the source using those tag bits, which are stripped before delivery.

---
 rtl/mem_req_arb.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mem_req_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arb.sv
`default_nettype none
// =============================================================================
// mem_req_arb : N-to-1 memory request arbiter, tag-routed 1-to-N response path
// Optional feature macro: MEM_ARB_PERF_EN (adds perf_req_stalls counter)
// Revision    : 1.0
// =============================================================================

module mem_req_arb_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  // Ready comes only from the registered occupancy, never from out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module mem_req_arb #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 8,
  parameter     TYPE         = "R",
  parameter int BUFFERED_REQ = 1,
  parameter int BUFFERED_RSP = 1,
  localparam int LOG_N         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_N,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQS-1:0]                      req_valid_in,
  input  logic [NUM_REQS-1:0]                      req_rw_in,
  input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]    req_byteen_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]    req_tag_in,
  output logic [NUM_REQS-1:0]                      req_ready_in,
  output logic                                     req_valid_out,
  output logic                                     req_rw_out,
  output logic [BYTEEN_WIDTH-1:0]                  req_byteen_out,
  output logic [ADDR_WIDTH-1:0]                    req_addr_out,
  output logic [DATA_WIDTH-1:0]                    req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]                 req_tag_out,
  input  logic                                     req_ready_out,
  input  logic                                     rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                    rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]                 rsp_tag_in,
  output logic                                     rsp_ready_in,
  output logic [NUM_REQS-1:0]                      rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]    rsp_tag_out,
  input  logic [NUM_REQS-1:0]                      rsp_ready_out
`ifdef MEM_ARB_PERF_EN
  ,output logic [31:0]                             perf_req_stalls
`endif
);
  localparam int IDX_W = (LOG_N > 0) ? LOG_N : 1;
  localparam int REQ_W = 1 + BYTEEN_WIDTH + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;
  localparam int RSP_W = IDX_W + TAG_IN_WIDTH + DATA_WIDTH;

  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
  logic                     lock_q, lock_d;
  logic [IDX_W-1:0]         arb_idx, grant_idx;
  logic                     arb_valid, grant_valid, lock_hit, stage_ready, req_fire;
  logic [TAG_OUT_WIDTH-1:0] sel_tag;
  logic [REQ_W-1:0]         sel_req, req_out_bus;

  if (TYPE == "P") begin : g_prio
    always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (req_valid_in[i]) begin
          arb_valid = 1'b1;
          arb_idx   = IDX_W'(i);
        end
      end
    end
  end else begin : g_rr
    logic [IDX_W-1:0] cand;
    // Walk downward so the last hit is the nearest index above the pointer.
    always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQS; k >= 1; k--) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQS);
        if (req_valid_in[cand]) begin
          arb_valid = 1'b1;
          arb_idx   = cand;
        end
      end
    end
  end

  // A presented-but-stalled grant is held so a newcomer cannot preempt it.
  assign lock_hit    = lock_q && req_valid_in[lock_idx_q];
  assign grant_idx   = lock_hit ? lock_idx_q : arb_idx;
  assign grant_valid = lock_hit || arb_valid;
  assign req_fire    = grant_valid && stage_ready;

  always_comb begin
    req_ready_in = '0;
    if (req_fire) req_ready_in[grant_idx] = 1'b1;
    lock_d     = grant_valid && !stage_ready;
    lock_idx_d = grant_idx;
    rr_ptr_d   = req_fire ? grant_idx : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= IDX_W'(NUM_REQS - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  if (NUM_REQS > 1) begin : g_tag_idx
    assign sel_tag = {req_tag_in[grant_idx], grant_idx};
  end else begin : g_tag_pass
    assign sel_tag = req_tag_in[0];
  end

  assign sel_req = {req_rw_in[grant_idx], req_byteen_in[grant_idx], req_addr_in[grant_idx],
                    req_data_in[grant_idx], sel_tag};

  if (BUFFERED_REQ != 0) begin : g_req_buf
    mem_req_arb_skid #(.WIDTH(REQ_W)) u_req_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (grant_valid),
      .in_ready  (stage_ready),
      .in_data   (sel_req),
      .out_valid (req_valid_out),
      .out_ready (req_ready_out),
      .out_data  (req_out_bus)
    );
  end else begin : g_req_comb
    assign stage_ready   = req_ready_out;
    assign req_valid_out = grant_valid;
    assign req_out_bus   = sel_req;
  end

  assign {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = req_out_bus;

  logic [IDX_W-1:0]        rsp_idx, route_idx;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_strip, route_tag;
  logic [DATA_WIDTH-1:0]   route_data;
  logic                    rsp_in_range, route_valid;
  logic [RSP_W-1:0]        rsp_in_bus, rsp_out_bus;

  if (NUM_REQS > 1) begin : g_rsp_idx
    assign rsp_idx       = rsp_tag_in[LOG_N-1:0];
    assign rsp_tag_strip = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_N];
    assign rsp_in_range  = ({1'b0, rsp_idx} < (IDX_W + 1)'(NUM_REQS));
  end else begin : g_rsp_single
    assign rsp_idx       = '0;
    assign rsp_tag_strip = rsp_tag_in;
    assign rsp_in_range  = 1'b1;
  end

  assign rsp_in_bus = {rsp_idx, rsp_tag_strip, rsp_data_in};

  // Out-of-range indices are accepted and silently dropped.
  if (BUFFERED_RSP != 0) begin : g_rsp_buf
    logic rsp_buf_ready;
    mem_req_arb_skid #(.WIDTH(RSP_W)) u_rsp_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rsp_valid_in && rsp_in_range),
      .in_ready  (rsp_buf_ready),
      .in_data   (rsp_in_bus),
      .out_valid (route_valid),
      .out_ready (rsp_ready_out[route_idx]),
      .out_data  (rsp_out_bus)
    );
    assign rsp_ready_in = rsp_in_range ? rsp_buf_ready : 1'b1;
  end else begin : g_rsp_comb
    assign route_valid  = rsp_valid_in && rsp_in_range;
    assign rsp_out_bus  = rsp_in_bus;
    assign rsp_ready_in = rsp_in_range ? rsp_ready_out[rsp_idx] : 1'b1;
  end

  assign {route_idx, route_tag, route_data} = rsp_out_bus;

  always_comb begin
    rsp_valid_out = '0;
    if (route_valid) rsp_valid_out[route_idx] = 1'b1;
  end

  assign rsp_data_out = {NUM_REQS{route_data}};
  assign rsp_tag_out  = {NUM_REQS{route_tag}};

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_stalls_d = perf_stalls_q;
    if (req_valid_out && !req_ready_out) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_stalls_q <= 32'd0;
    else        perf_stalls_q <= perf_stalls_d;
  end

  assign perf_req_stalls = perf_stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arb.sv
`default_nettype none
// tb_mem_req_arb : directed checks of a buffered round-robin instance (u_rr)
// and an unbuffered fixed-priority instance (u_pr) sharing one stimulus.

module tb_mem_req_arb;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int TOW = 10;
  localparam int BW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_rw, rsp_ready;
  logic [N-1:0][BW-1:0]  req_byteen;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][DW-1:0]  req_data;
  logic [N-1:0][TW-1:0]  req_tag;
  logic                  mem_ready, rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic [TOW-1:0]        rsp_tag;

  logic [N-1:0]          rr_req_ready_in, pr_req_ready_in, rr_rsp_valid_out, pr_rsp_valid_out;
  logic                  rr_req_valid_out, pr_req_valid_out, rr_req_rw_out, pr_req_rw_out;
  logic [BW-1:0]         rr_req_byteen_out, pr_req_byteen_out;
  logic [AW-1:0]         rr_req_addr_out, pr_req_addr_out;
  logic [DW-1:0]         rr_req_data_out, pr_req_data_out;
  logic [TOW-1:0]        rr_req_tag_out, pr_req_tag_out;
  logic                  rr_rsp_ready_in, pr_rsp_ready_in;
  logic [N-1:0][DW-1:0]  rr_rsp_data_out, pr_rsp_data_out;
  logic [N-1:0][TW-1:0]  rr_rsp_tag_out, pr_rsp_tag_out;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]           rr_perf, pr_perf;
`endif

  mem_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW),
                .TYPE("R"), .BUFFERED_REQ(1), .BUFFERED_RSP(1)) u_rr (
    .clk            (clk),
    .reset          (rst_n),
    .req_valid_in   (req_valid),
    .req_rw_in      (req_rw),
    .req_byteen_in  (req_byteen),
    .req_addr_in    (req_addr),
    .req_data_in    (req_data),
    .req_tag_in     (req_tag),
    .req_ready_in   (rr_req_ready_in),
    .req_valid_out  (rr_req_valid_out),
    .req_rw_out     (rr_req_rw_out),
    .req_byteen_out (rr_req_byteen_out),
    .req_addr_out   (rr_req_addr_out),
    .req_data_out   (rr_req_data_out),
    .req_tag_out    (rr_req_tag_out),
    .req_ready_out  (mem_ready),
    .rsp_valid_in   (rsp_valid),
    .rsp_data_in    (rsp_data),
    .rsp_tag_in     (rsp_tag),
    .rsp_ready_in   (rr_rsp_ready_in),
    .rsp_valid_out  (rr_rsp_valid_out),
    .rsp_data_out   (rr_rsp_data_out),
    .rsp_tag_out    (rr_rsp_tag_out),
    .rsp_ready_out  (rsp_ready)
`ifdef MEM_ARB_PERF_EN
    ,.perf_req_stalls (rr_perf)
`endif
  );

  mem_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW),
                .TYPE("P"), .BUFFERED_REQ(0), .BUFFERED_RSP(0)) u_pr (
    .clk            (clk),
    .reset          (rst_n),
    .req_valid_in   (req_valid),
    .req_rw_in      (req_rw),
    .req_byteen_in  (req_byteen),
    .req_addr_in    (req_addr),
    .req_data_in    (req_data),
    .req_tag_in     (req_tag),
    .req_ready_in   (pr_req_ready_in),
    .req_valid_out  (pr_req_valid_out),
    .req_rw_out     (pr_req_rw_out),
    .req_byteen_out (pr_req_byteen_out),
    .req_addr_out   (pr_req_addr_out),
    .req_data_out   (pr_req_data_out),
    .req_tag_out    (pr_req_tag_out),
    .req_ready_out  (mem_ready),
    .rsp_valid_in   (rsp_valid),
    .rsp_data_in    (rsp_data),
    .rsp_tag_in     (rsp_tag),
    .rsp_ready_in   (pr_rsp_ready_in),
    .rsp_valid_out  (pr_rsp_valid_out),
    .rsp_data_out   (pr_rsp_data_out),
    .rsp_tag_out    (pr_rsp_tag_out),
    .rsp_ready_out  (rsp_ready)
`ifdef MEM_ARB_PERF_EN
    ,.perf_req_stalls (pr_perf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge; check point: the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0; req_data = '0; req_tag = '0;
    mem_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0; rsp_tag = '0; rsp_ready = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_tag[i]    = TW'(8'h10 + i);
      req_addr[i]   = AW'(26'h100 + i);
      req_data[i]   = DW'(32'hD0 + i);
      req_byteen[i] = 4'hF;
    end

    // Reset state
    tick(); tick(); settle();
    check("reset_req_valid", rr_req_valid_out, 1'b0);
    check("reset_rsp_valid", rr_rsp_valid_out, 4'b0000);

    // Round-robin with all four requesting continuously
    tick();
    rst_n = 1'b1; req_valid = 4'b1111;
    settle();
    check("rr_first_grant", rr_req_ready_in, 4'b0001);
    check("rr_latency", rr_req_valid_out, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      check("rr_stream_valid", rr_req_valid_out, 1'b1);
      check("rr_stream_tag", rr_req_tag_out, {8'h10 + 8'(k % 4), 2'(k % 4)});
      check("rr_stream_ready", rr_req_ready_in, 4'b0001 << ((k + 1) % 4));
    end
    tick();
    req_valid = 4'b0000;
    settle();
    check("rr_last_tag", rr_req_tag_out, 10'h045);
    tick(); settle();
    check("rr_drained", rr_req_valid_out, 1'b0);

    // Single request from requester 2
    tick();
    req_valid = 4'b0100; req_tag[2] = 8'h5A; req_addr[2] = 26'h123;
    req_rw[2] = 1'b1; req_byteen[2] = 4'hA; req_data[2] = 32'h1234_5678;
    settle();
    check("req2_ready_in", rr_req_ready_in, 4'b0100);
    tick();
    req_valid = 4'b0000;
    settle();
    check("req2_tag_out", rr_req_tag_out, 10'h16A);
    check("req2_addr_out", rr_req_addr_out, 26'h123);
    check("req2_rw_out", rr_req_rw_out, 1'b1);
    check("req2_byteen_out", rr_req_byteen_out, 4'hA);
    check("req2_data_out", rr_req_data_out, 32'h1234_5678);
    tick(); settle();
    check("req2_no_dup", rr_req_valid_out, 1'b0);

    // Response routing
    tick();
    rsp_valid = 1'b1; rsp_tag = 10'h16A; rsp_data = 32'hDEAD_BEEF; rsp_ready = 4'b0100;
    settle();
    check("rsp_buf_latency", rr_rsp_valid_out, 4'b0000);
    check("rsp_buf_ready_in", rr_rsp_ready_in, 1'b1);
    check("rsp_comb_valid", pr_rsp_valid_out, 4'b0100);
    check("rsp_comb_tag", pr_rsp_tag_out[2], 8'h5A);
    tick();
    rsp_valid = 1'b0;
    settle();
    check("rsp_buf_valid", rr_rsp_valid_out, 4'b0100);
    check("rsp_buf_tag", rr_rsp_tag_out[2], 8'h5A);
    check("rsp_buf_data", rr_rsp_data_out[2], 32'hDEAD_BEEF);
    tick();
    rsp_valid = 1'b1; rsp_tag = 10'h19B; rsp_ready = 4'b0111;
    settle();
    check("rsp_comb_stall_valid", pr_rsp_valid_out, 4'b1000);
    check("rsp_comb_stall_ready", pr_rsp_ready_in, 1'b0);
    check("rsp_buf_after_pop", rr_rsp_valid_out, 4'b0000);
    tick();
    rsp_valid = 1'b0;
    settle();
    check("rsp_buf_port3_valid", rr_rsp_valid_out, 4'b1000);
    check("rsp_buf_port3_tag", rr_rsp_tag_out[3], 8'h66);
    tick();
    rsp_ready = 4'b1111;
    settle();
    check("rsp_buf_port3_held", rr_rsp_valid_out, 4'b1000);
    tick(); settle();
    check("rsp_buf_empty", rr_rsp_valid_out, 4'b0000);

    // Backpressure on the buffered request output
    tick();
    mem_ready = 1'b0; req_valid = 4'b0010; req_tag[1] = 8'h21; req_addr[1] = 26'h201;
    settle();
    check("bp_req1_ready_in", rr_req_ready_in, 4'b0010);
    tick();
    req_valid = 4'b0000;
    settle();
    check("bp_req1_presented", rr_req_tag_out, 10'h085);
    for (int s = 2; s <= 5; s++) begin
      tick();
      if (s == 2) begin
        req_valid = 4'b0001; req_tag[0] = 8'h31; req_addr[0] = 26'h301;
      end
      if (s == 3) req_valid = 4'b0000;
      settle();
      check("bp_hold_valid", rr_req_valid_out, 1'b1);
      check("bp_hold_tag", rr_req_tag_out, 10'h085);
      check("bp_hold_addr", rr_req_addr_out, 26'h201);
      if (s == 2) check("bp_req0_skid_ready", rr_req_ready_in, 4'b0001);
    end
    tick();
    mem_ready = 1'b1;
    settle();
    check("bp_req1_first", rr_req_tag_out, 10'h085);
`ifdef MEM_ARB_PERF_EN
    check("perf_req_stalls", rr_perf, 32'd5);
`endif
    tick(); settle();
    check("bp_req0_second", rr_req_tag_out, 10'h0C4);
    tick(); settle();
    check("bp_drained", rr_req_valid_out, 1'b0);

    // Fixed priority, unbuffered
    tick();
    req_valid = 4'b1010; req_tag[3] = 8'h13;
    settle();
    check("pr_grant1_ready", pr_req_ready_in, 4'b0010);
    check("pr_grant1_tag", pr_req_tag_out, 10'h085);
    tick();
    req_valid = 4'b1001;
    settle();
    check("pr_grant0_ready", pr_req_ready_in, 4'b0001);
    check("pr_grant0_tag", pr_req_tag_out, 10'h0C4);
    tick();
    req_valid = 4'b1000;
    settle();
    check("pr_grant3_ready", pr_req_ready_in, 4'b1000);
    check("pr_grant3_tag", pr_req_tag_out, 10'h04F);
    tick();
    req_valid = 4'b0000;
    settle();
    check("pr_idle", pr_req_valid_out, 1'b0);

    // Grant lock: a stalled grant to 1 is not preempted by requester 0
    tick();
    mem_ready = 1'b0; req_valid = 4'b1010;
    settle();
    check("lock_presented", pr_req_tag_out, 10'h085);
    check("lock_stall_ready", pr_req_ready_in, 4'b0000);
    tick();
    req_valid = 4'b1011;
    settle();
    check("lock_held_tag", pr_req_tag_out, 10'h085);
    tick();
    mem_ready = 1'b1;
    settle();
    check("lock_release_ready", pr_req_ready_in, 4'b0010);
    tick();
    req_valid = 4'b1001;
    settle();
    check("lock_next_grant", pr_req_tag_out, 10'h0C4);
    tick();
    req_valid = 4'b0000;

    // Asynchronous reset in the middle of traffic
    tick();
    req_valid = 4'b1111; mem_ready = 1'b1;
    rsp_valid = 1'b1; rsp_tag = 10'h1DD; rsp_ready = 4'b0000;
    tick(); tick();
    #2;
    check("pre_reset_req_valid", rr_req_valid_out, 1'b1);
    check("pre_reset_rsp_valid", rr_rsp_valid_out, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("async_reset_req_valid", rr_req_valid_out, 1'b0);
    check("async_reset_rsp_valid", rr_rsp_valid_out, 4'b0000);
    rsp_valid = 1'b0; rsp_ready = 4'b1111;
    tick(); tick();
    rst_n = 1'b1;
    settle();
    check("post_reset_grant0", rr_req_ready_in, 4'b0001);
    tick(); settle();
    check("post_reset_tag0", rr_req_tag_out, 10'h0C4);
    check("post_reset_next", rr_req_ready_in, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
